// File: rtl/memo_arb_pkg.sv
// Shared types, default sizes and the round-robin search helper for memo_arbiter.
package memo_arb_pkg;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } memo_arb_state_t;

  localparam int unsigned DEF_AW    = 6;
  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_DEPTH = 1 << DEF_AW;
  localparam int unsigned MAX_NREQ  = 4;
  localparam int unsigned PTR_W     = 2;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } rr_pick_t;

  // First valid requester at or above ptr, wrapping modulo nreq.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                       input logic [PTR_W-1:0]    ptr,
                                       input int unsigned         nreq);
    rr_pick_t    r;
    int unsigned cand;
    r = '0;
    for (int unsigned k = 0; k < MAX_NREQ; k++) begin
      cand = (32'(ptr) + k) % nreq;
      if ((k < nreq) && !r.found && valid[PTR_W'(cand)]) begin
        r.found = 1'b1;
        r.idx   = PTR_W'(cand);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/memo_rr_arbiter.sv
// Round-robin picker with registered priority pointer.
// Ports:
//   clock, reset_n : clock, async active-low reset
//   i_valid        : per-requester request bits
//   i_take         : a grant is being consumed this cycle (advances pointer)
//   o_grant_c      : one-hot winner (zero when nothing valid), combinational
//   o_found_c      : some requester is valid, combinational
//   o_winner_c     : winner index, combinational
module memo_rr_arbiter
  import memo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  i_valid,
  input  logic             i_take,
  output logic [NREQ-1:0]  o_grant_c,
  output logic             o_found_c,
  output logic [PTR_W-1:0] o_winner_c
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  rr_pick_t         w_pick;

  // Search from the pointer; the next pointer sits just past the winner.
  always_comb begin
    w_pick     = rr_pick(MAX_NREQ'(i_valid), r_ptr, NREQ);
    o_found_c  = w_pick.found;
    o_winner_c = w_pick.idx;
    o_grant_c  = '0;
    if (w_pick.found) begin
      o_grant_c = NREQ'(1) << w_pick.idx;
    end
    w_ptr_nxt = (32'(w_pick.idx) == NREQ - 1) ? '0 : w_pick.idx + PTR_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_take && w_pick.found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/memo_arbiter.sv
// Round-robin sharing of one single-port synchronous RAM among NREQ requesters,
// with a sequenced whole-RAM clear engine.
// Ports:
//   clock, reset_n         : clock, async active-low reset
//   req_valid/req_ready    : request handshake, ready is one-hot and combinational
//   req_we/addr/wdata      : flattened per-requester request fields
//   rsp_valid/rsp_rdata    : registered one-hot strobe one cycle after acceptance;
//                            rdata is the RAM q passthrough
//   clear_start/busy/done  : clear engine control and status
//   mem_address/data/wren  : RAM pins (combinational), mem_q : RAM read data
module memo_arbiter
  import memo_arb_pkg::*;
#(
  parameter int unsigned   NREQ      = 2,
  parameter int unsigned   AW        = DEF_AW,
  parameter int unsigned   DW        = DEF_DW,
  parameter logic [DW-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [AW-1:0]     mem_address,
  output logic [DW-1:0]     mem_data,
  output logic              mem_wren,
  input  logic [DW-1:0]     mem_q
);

  localparam int unsigned DEPTH = 1 << AW;

  memo_arb_state_t  r_state;
  memo_arb_state_t  w_state_nxt;
  logic [AW-1:0]    r_clear_cnt;
  logic [AW-1:0]    w_clear_cnt_nxt;
  logic [NREQ-1:0]  r_rsp_valid;
  logic [NREQ-1:0]  w_rsp_valid_nxt;
  logic             r_clear_busy;
  logic             w_clear_busy_nxt;
  logic             r_clear_done;
  logic             w_clear_done_nxt;

  logic             w_arb_en;
  logic             w_take;
  logic [NREQ-1:0]  w_grant;
  logic             w_found;
  logic [PTR_W-1:0] w_winner;

  // Arbitration only in SERVE, and a clear request pre-empts every requester.
  assign w_arb_en = reset_n && (r_state == SERVE) && !clear_start;
  assign w_take   = w_arb_en && w_found;

  memo_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_valid    (req_valid),
    .i_take     (w_take),
    .o_grant_c  (w_grant),
    .o_found_c  (w_found),
    .o_winner_c (w_winner)
  );

  // Next-state, RAM pin muxing and handshake outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_clear_cnt_nxt  = r_clear_cnt;
    w_rsp_valid_nxt  = '0;
    w_clear_busy_nxt = r_clear_busy;
    w_clear_done_nxt = 1'b0;
    req_ready        = '0;
    mem_address      = '0;
    mem_data         = '0;
    mem_wren         = 1'b0;

    case (r_state)
      SERVE: begin
        if (clear_start) begin
          w_state_nxt      = CLEAR;
          w_clear_cnt_nxt  = '0;
          w_clear_busy_nxt = 1'b1;
        end else if (w_found) begin
          req_ready       = w_grant;
          w_rsp_valid_nxt = w_grant;
          for (int i = 0; i < NREQ; i++) begin
            if (w_winner == PTR_W'(i)) begin
              mem_address = req_addr[i*AW +: AW];
              mem_data    = req_wdata[i*DW +: DW];
              mem_wren    = req_we[i];
            end
          end
        end
      end
      CLEAR: begin
        mem_wren        = 1'b1;
        mem_address     = r_clear_cnt;
        mem_data        = CLEAR_VAL;
        w_clear_cnt_nxt = r_clear_cnt + AW'(1);
        if (r_clear_cnt == AW'(DEPTH - 1)) begin
          w_state_nxt      = SERVE;
          w_clear_cnt_nxt  = '0;
          w_clear_busy_nxt = 1'b0;
          w_clear_done_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = SERVE;
      end
    endcase

    // RAM pins and ready must be quiet the moment reset asserts.
    if (!reset_n) begin
      req_ready   = '0;
      mem_address = '0;
      mem_data    = '0;
      mem_wren    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= SERVE;
      r_clear_cnt  <= '0;
      r_rsp_valid  <= '0;
      r_clear_busy <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clear_cnt  <= w_clear_cnt_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_clear_busy <= w_clear_busy_nxt;
      r_clear_done <= w_clear_done_nxt;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = mem_q;
  assign clear_busy = r_clear_busy;
  assign clear_done = r_clear_done;

endmodule

// File: tb/tb_memo_arbiter.sv
// Bench for memo_arbiter: behavioural RAM, reference model with per-cycle compare,
// directed scenarios with literal expectations, and randomized traffic.
module tb_memo_arbiter;

  localparam int NREQ  = 2;
  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam logic [7:0] CV = 8'h00;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [11:0] req_addr;
  logic [15:0] req_wdata;
  logic [7:0]  rsp_rdata;
  logic        clear_start, clear_busy, clear_done;
  logic [5:0]  mem_address;
  logic [7:0]  mem_data, mem_q;
  logic        mem_wren;

  memo_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .CLEAR_VAL(CV)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // Single-port RAM: registered read, read-before-write.
  logic [7:0] tb_ram [DEPTH];
  always @(posedge clock) begin
    mem_q <= tb_ram[mem_address];
    if (mem_wren) tb_ram[mem_address] <= mem_data;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  bit         chk_on = 1'b0;
  int         m_ptr = 0;
  int         m_cnt = 0;
  bit         m_clearing = 1'b0;
  bit         m_done = 1'b0;
  logic [1:0] m_rsp = 2'b00;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] gold [DEPTH];

  // Compare every cycle, then advance the model across the coming edge.
  always @(negedge clock) begin
    #3;
    if (chk_on) begin
      if (!reset_n) begin
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wren",  32'(mem_wren), 32'd0);
        chk("rst_addr",  32'(mem_address), 32'd0);
        chk("rst_data",  32'(mem_data), 32'd0);
        chk("rst_rspv",  32'(rsp_valid), 32'd0);
        chk("rst_busy",  32'(clear_busy), 32'd0);
        chk("rst_done",  32'(clear_done), 32'd0);
        m_ptr = 0; m_cnt = 0; m_clearing = 1'b0; m_done = 1'b0; m_rsp = 2'b00;
      end else begin : model
        int         w;
        int         a;
        logic [1:0] er;
        w = -1;
        if (!m_clearing && !clear_start) begin
          for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
          end
        end
        er = (w >= 0) ? 2'(1 << w) : 2'b00;
        chk("ready", 32'(req_ready), 32'(er));
        if (m_clearing) begin
          chk("clr_wren", 32'(mem_wren), 32'd1);
          chk("clr_addr", 32'(mem_address), 32'(m_cnt));
          chk("clr_data", 32'(mem_data), 32'(CV));
        end else if (w >= 0) begin
          chk("mem_wren", 32'(mem_wren), 32'(req_we[w]));
          chk("mem_addr", 32'(mem_address), 32'(req_addr[w*AW +: AW]));
          chk("mem_data", 32'(mem_data), 32'(req_wdata[w*DW +: DW]));
        end else begin
          chk("idle_wren", 32'(mem_wren), 32'd0);
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
        if (m_rsp != 2'b00) chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        chk("busy", 32'(clear_busy), 32'(m_clearing));
        chk("done", 32'(clear_done), 32'(m_done));

        m_done = 1'b0;
        m_rsp  = 2'b00;
        if (m_clearing) begin
          gold[m_cnt] = CV;
          m_cnt++;
          if (m_cnt == DEPTH) begin
            m_clearing = 1'b0;
            m_done     = 1'b1;
          end
        end else if (clear_start) begin
          m_clearing = 1'b1;
          m_cnt      = 0;
        end else if (w >= 0) begin
          a       = int'(req_addr[w*AW +: AW]);
          m_rsp   = er;
          m_rdata = gold[a];
          if (req_we[w]) gold[a] = req_wdata[w*DW +: DW];
          m_ptr = (w + 1) % NREQ;
        end
      end
    end
  end

  // Drive one cycle of inputs; returns once outputs have settled.
  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [5:0] a0, input logic [5:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1, input logic cs);
    @(negedge clock);
    #1;
    req_valid   = v;
    req_we      = we;
    req_addr    = {a1, a0};
    req_wdata   = {d1, d0};
    clear_start = cs;
    #3;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 6'h00, 6'h00, 8'h00, 8'h00, 1'b0);
  endtask

  function automatic logic [7:0] exp_of(input int a, input int lim);
    return (a < lim) ? 8'h00 : (8'h80 | 8'(a));
  endfunction

  // Read every address via requester 0 and compare against a literal pattern.
  task automatic sweep(input int lim, input string nm);
    for (int a = 0; a < DEPTH; a++) begin
      drive(2'b01, 2'b00, 6'(a), 6'h00, 8'h00, 8'h00, 1'b0);
      if (a > 0) chk(nm, 32'(rsp_rdata), 32'(exp_of(a - 1, lim)));
    end
    idle();
    chk(nm, 32'(rsp_rdata), 32'(exp_of(DEPTH - 1, lim)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stim
    int first_ready;
    int done_at;
    int done_cnt;
    int guard;

    req_valid = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0; clear_start = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      tb_ram[a] = 8'(a * 37 + 11);
      gold[a]   = 8'(a * 37 + 11);
    end
    tb_ram[5]  = 8'h12; gold[5]  = 8'h12;
    tb_ram[16] = 8'hAA; gold[16] = 8'hAA;
    chk_on = 1'b1;

    repeat (3) @(negedge clock);
    #1 reset_n = 1'b1;

    // Single read, same-cycle ready, response one cycle later
    drive(2'b01, 2'b00, 6'h05, 6'h00, 8'h00, 8'h00, 1'b0);
    chk("t1_ready", 32'(req_ready), 32'h1);
    idle();
    chk("t1_rspv", 32'(rsp_valid), 32'h1);
    chk("t1_rdata", 32'(rsp_rdata), 32'h12);

    // Both valid: pointer is past requester 0, so grants go 10,01,10,01
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b00, 6'h01, 6'h02, 8'h00, 8'h00, 1'b0);
      chk("t2_grant", 32'(req_ready), (i % 2 == 0) ? 32'h2 : 32'h1);
      if (i > 0) chk("t2_rsp", 32'(rsp_valid), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    idle();
    chk("t2_rsp_last", 32'(rsp_valid), 32'h1);

    // Write returns old data, following read sees new data
    drive(2'b10, 2'b10, 6'h00, 6'h10, 8'h00, 8'h5A, 1'b0);
    chk("t3_wready", 32'(req_ready), 32'h2);
    drive(2'b01, 2'b00, 6'h10, 6'h00, 8'h00, 8'h00, 1'b0);
    chk("t3_rready", 32'(req_ready), 32'h1);
    chk("t3_wrspv", 32'(rsp_valid), 32'h2);
    chk("t3_wold", 32'(rsp_rdata), 32'hAA);
    idle();
    chk("t3_rrspv", 32'(rsp_valid), 32'h1);
    chk("t3_rnew", 32'(rsp_rdata), 32'h5A);

    // Clear while both valid, with an ignored re-start at clear_cnt=20
    drive(2'b11, 2'b00, 6'h01, 6'h02, 8'h00, 8'h00, 1'b1);
    chk("t4_start_ready", 32'(req_ready), 32'h0);
    first_ready = -1; done_at = -1; done_cnt = 0;
    for (int c = 1; c < 200; c++) begin
      drive(2'b11, 2'b00, 6'h01, 6'h02, 8'h00, 8'h00, (c == 21));
      if (c == 1) chk("t4_busy", 32'(clear_busy), 32'h1);
      if (clear_done) begin
        done_cnt++;
        done_at = c;
      end
      if (req_ready != 2'b00 && first_ready < 0) first_ready = c;
      if (first_ready >= 0 && c >= first_ready + 2) break;
    end
    chk("t4_ready_low_cycles", 32'(first_ready), 32'd65);
    chk("t4_done_at", 32'(done_at), 32'd65);
    chk("t4_done_count", 32'(done_cnt), 32'd1);
    idle();
    sweep(DEPTH, "t4_zero");

    // Random traffic with occasional clears
    repeat (600) begin
      drive(2'($urandom), 2'($urandom), 6'($urandom), 6'($urandom),
            8'($urandom), 8'($urandom), ($urandom_range(0, 99) == 0));
    end
    guard = 0;
    idle();
    while (clear_busy && guard < 100) begin
      idle();
      guard++;
    end
    chk("t5_settle", 32'(clear_busy), 32'h0);

    // Known fill, then reset in the cycle clear_cnt reaches 30
    for (int a = 0; a < DEPTH; a++) begin
      drive(2'b01, 2'b01, 6'(a), 6'h00, 8'h80 | 8'(a), 8'h00, 1'b0);
    end
    idle();
    drive(2'b00, 2'b00, 6'h00, 6'h00, 8'h00, 8'h00, 1'b1);
    for (int c = 1; c <= 30; c++) idle();
    @(negedge clock);
    #1 reset_n = 1'b0;
    #3;
    chk("t6_rst_wren", 32'(mem_wren), 32'h0);
    chk("t6_rst_busy", 32'(clear_busy), 32'h0);
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      idle();
      if (clear_done) done_cnt++;
    end
    chk("t6_no_done", 32'(done_cnt), 32'h0);
    sweep(30, "t6_partial");

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
